// File: rtl/fp_divider_if.sv
// ---------------------------------------------------------------------------
// fp_divider_if
// Operand/result bundle for fp_divider.
//
// Handshake rules (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. A producer holding valid high keeps its data
// stable until the transfer. A consumer may drive ready freely; ready does not
// depend on valid.
//
// Signals
//   in_valid  operands x/y valid              (master -> slave)
//   in_ready  divider can take operands       (slave  -> master)
//   x, y      dividend / divisor, IEEE single (master -> slave)
//   out_valid result valid, held until taken  (slave  -> master)
//   out_ready consumer takes result           (master -> slave)
//   result    quotient, IEEE single           (slave  -> master)
//   flags     {invalid, div_by_zero, overflow, underflow}
// ---------------------------------------------------------------------------
interface fp_divider_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic [31:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;

  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fp_divider.sv
// ---------------------------------------------------------------------------
// fp_divider
// Sequential IEEE-754 single-precision divider, result = x / y.
// Restoring radix-2 mantissa division (one quotient bit per clock) followed by
// round-to-nearest-even. Subnormal operands are flushed to zero.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   bus        fp_divider_if.slave: in_valid/in_ready/x/y on the operand side,
//              out_valid/out_ready/result/flags on the result side
//   dbg_state  current FSM state (0 IDLE, 1 DIV, 2 ROUND, 3 DONE)
//
// Timing: a normal operation raises out_valid on the 28th edge counting the
// accepting edge as the first; special operands raise it on the accepting
// edge itself.
// ---------------------------------------------------------------------------
module fp_divider (
  input  logic         clk,
  input  logic         reset,
  fp_divider_if.slave  bus,
  output logic [1:0]   dbg_state
);

  // 24 mantissa bits + guard + one bit for the quotient being in [0.5, 2)
  localparam int QBITS = 26;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic              sign_r;
  logic signed [9:0] exp_r;
  logic [23:0]       mb_r;
  logic [24:0]       rem_r;
  logic [QBITS-1:0]  q_r;
  logic [4:0]        cnt_r;
  logic [31:0]       result_r;
  logic [3:0]        flags_r;

  // ---------------- operand classification (sampled in IDLE) ----------------
  logic x_zero, x_max, x_nan, x_inf;
  logic y_zero, y_max, y_nan, y_inf;
  logic in_sign;
  logic special_hit;
  logic [31:0] special_res;
  logic [3:0]  special_flags;

  always_comb begin
    x_zero  = (bus.x[30:23] == 8'd0);
    x_max   = (bus.x[30:23] == 8'hFF);
    x_nan   = x_max & (|bus.x[22:0]);
    x_inf   = x_max & ~(|bus.x[22:0]);
    y_zero  = (bus.y[30:23] == 8'd0);
    y_max   = (bus.y[30:23] == 8'hFF);
    y_nan   = y_max & (|bus.y[22:0]);
    y_inf   = y_max & ~(|bus.y[22:0]);
    in_sign = bus.x[31] ^ bus.y[31];

    // Any zero/inf/NaN operand bypasses the mantissa divider.
    special_hit   = x_zero | x_max | y_zero | y_max;
    special_res   = {in_sign, 31'd0};
    special_flags = 4'b0000;
    if (x_nan | y_nan | (x_zero & y_zero) | (x_inf & y_inf)) begin
      special_res   = 32'h7FC0_0000;
      special_flags = 4'b1000;
    end else if (y_zero & ~x_inf) begin
      // x is finite and non-zero here: 0/0 was caught above
      special_res   = {in_sign, 31'h7F80_0000};
      special_flags = 4'b0100;
    end else if (x_inf) begin
      special_res   = {in_sign, 31'h7F80_0000};
    end
    // remaining cases (finite/inf, 0/nonzero) keep the signed zero default
  end

  // ---------------- one restoring division step ----------------
  logic        rem_ge;
  logic [24:0] rem_diff;
  logic [24:0] rem_keep;
  logic [24:0] rem_next;

  always_comb begin
    rem_ge   = (rem_r >= {1'b0, mb_r});
    rem_diff = rem_r - {1'b0, mb_r};
    rem_keep = rem_ge ? rem_diff : rem_r;
    // rem_keep < mb < 2^24, so the shift never loses a set bit
    rem_next = rem_keep << 1;
  end

  // ---------------- normalise + round-to-nearest-even ----------------
  logic [22:0]        man_t;
  logic               g_bit;
  logic               s_bit;
  logic               inc;
  logic [23:0]        man_inc;
  logic signed [10:0] e_base;
  logic signed [10:0] e_fin;
  logic [31:0]        round_res;
  logic [3:0]         round_flags;

  always_comb begin
    // q_r[25] carries weight 2^0; the quotient of two [1,2) mantissas is in (0.5, 2)
    if (q_r[25]) begin
      man_t  = q_r[24:2];
      g_bit  = q_r[1];
      s_bit  = q_r[0] | (|rem_r);
      e_base = {exp_r[9], exp_r} + 11'sd127;
    end else begin
      man_t  = q_r[23:1];
      g_bit  = q_r[0];
      s_bit  = |rem_r;
      e_base = {exp_r[9], exp_r} + 11'sd126;
    end
    inc     = g_bit & (s_bit | man_t[0]);
    man_inc = {1'b0, man_t} + {23'd0, inc};
    // carry out of the fraction: mantissa wraps to zero, exponent bumps
    e_fin   = man_inc[23] ? (e_base + 11'sd1) : e_base;

    round_flags = 4'b0000;
    round_res   = {sign_r, e_fin[7:0], man_inc[22:0]};
    if (e_fin >= 11'sd255) begin
      round_res   = {sign_r, 31'h7F80_0000};
      round_flags = 4'b0010;
    end else if (e_fin <= 11'sd0) begin
      round_res   = {sign_r, 31'd0};
      round_flags = 4'b0001;
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (bus.in_valid) state_next = special_hit ? DONE : DIV;
      DIV:   if (cnt_r == 5'(QBITS - 1)) state_next = ROUND;
      ROUND: state_next = DONE;
      DONE:  if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      sign_r   <= 1'b0;
      exp_r    <= '0;
      mb_r     <= '0;
      rem_r    <= '0;
      q_r      <= '0;
      cnt_r    <= '0;
      result_r <= '0;
      flags_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sign_r <= in_sign;
            exp_r  <= $signed({2'b00, bus.x[30:23]}) - $signed({2'b00, bus.y[30:23]});
            mb_r   <= {1'b1, bus.y[22:0]};
            rem_r  <= {2'b01, bus.x[22:0]};
            q_r    <= '0;
            cnt_r  <= '0;
            if (special_hit) begin
              result_r <= special_res;
              flags_r  <= special_flags;
            end
          end
        end
        DIV: begin
          rem_r <= rem_next;
          q_r   <= {q_r[QBITS-2:0], rem_ge};
          cnt_r <= cnt_r + 5'd1;
        end
        ROUND: begin
          result_r <= round_res;
          flags_r  <= round_flags;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_r;
  assign bus.flags     = flags_r;
  assign dbg_state     = state;

endmodule
